// File: rtl/adj_count_engine.sv
// Minesweeper adjacency-count engine: snapshots a mine map on start and scans
// the board LANES tiles per cycle, writing each tile's 8-neighbour mine count.
module adj_count_engine #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned LANES      = 1,
    parameter int unsigned MARK_MINES = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ROWS*COLS-1:0]       mine_map,
    output logic [4*ROWS*COLS-1:0]     adj,
    output logic                       busy,
    output logic                       ready,
    output logic                       done
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned IW = $clog2(N + LANES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      w_idx_end;
    logic               w_accept;
    logic               w_last;
    logic [N-1:0]       r_map;
    logic [4*N-1:0]     r_adj;
    logic               r_busy;
    logic               r_ready;
    logic               r_done;
    logic [N-1:0]       w_we;
    logic [N-1:0][3:0]  w_val;

    // Flat index of neighbour d (0..7, centre skipped) of tile t, or -1 if off-board.
    function automatic int nb_idx(input int t, input int d);
        int dd;
        int rr;
        int cc;
        dd = (d < 4) ? d : d + 1;
        rr = t / int'(COLS) + dd / 3 - 1;
        cc = t % int'(COLS) + dd % 3 - 1;
        if (rr >= 0 && rr < int'(ROWS) && cc >= 0 && cc < int'(COLS)) begin
            return rr * int'(COLS) + cc;
        end
        return -1;
    endfunction

    // Per-tile entry from the snapshot; neighbour wiring is fixed at elaboration.
    for (genvar g = 0; g < int'(N); g++) begin : g_tile
        logic [7:0] w_nb;
        for (genvar d = 0; d < 8; d++) begin : g_nb
            localparam int J = nb_idx(g, d);
            if (J >= 0) begin : g_on
                assign w_nb[d] = r_map[J];
            end else begin : g_off
                assign w_nb[d] = 1'b0;
            end
        end
        assign w_val[g] = ((MARK_MINES != 0) && r_map[g]) ? 4'hF : 4'($countones(w_nb));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_idx_end   = r_idx + IW'(LANES);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_idx_end >= IW'(N)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tiles covered by the current lane group; lanes past the board end select nothing.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_we[i] = (r_state == S_SCAN) && (IW'(i) >= r_idx) && (IW'(i) < w_idx_end);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_map   <= '0;
            r_adj   <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else if (w_accept) begin
            r_map   <= mine_map;
            r_idx   <= '0;
            r_adj   <= '0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else if (r_state == S_SCAN) begin
            for (int i = 0; i < int'(N); i++) begin
                if (w_we[i]) begin
                    r_adj[4*i +: 4] <= w_val[i];
                end
            end
            r_idx <= w_idx_end;
            if (w_last) begin
                r_busy  <= 1'b0;
                r_ready <= 1'b1;
                r_done  <= 1'b1;
            end
        end
    end

    assign adj   = r_adj;
    assign busy  = r_busy;
    assign ready = r_ready;
    assign done  = r_done;

endmodule

// File: tb/tb_adj_count_engine.sv
// Scoreboard bench for adj_count_engine: three board configurations, expected
// results queued at stimulus time and checked by per-instance monitors on done.
module tb_adj_count_engine;

    typedef struct {
        logic [255:0] adj;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_start, b_start, c_start;
    logic [63:0]  a_map, b_map;
    logic [19:0]  c_map;
    logic [255:0] a_adj, b_adj;
    logic [79:0]  c_adj;
    logic         a_busy, a_ready, a_done;
    logic         b_busy, b_ready, b_done;
    logic         c_busy, c_ready, c_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   t_start[3];
    bit   prev_busy[3];
    bit   prev_done[3];

    adj_count_engine #(.ROWS(8), .COLS(8), .LANES(1), .MARK_MINES(0)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .mine_map(a_map),
        .adj(a_adj), .busy(a_busy), .ready(a_ready), .done(a_done));

    adj_count_engine #(.ROWS(8), .COLS(8), .LANES(5), .MARK_MINES(1)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .mine_map(b_map),
        .adj(b_adj), .busy(b_busy), .ready(b_ready), .done(b_done));

    adj_count_engine #(.ROWS(4), .COLS(5), .LANES(3), .MARK_MINES(0)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .mine_map(c_map),
        .adj(c_adj), .busy(c_busy), .ready(c_ready), .done(c_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference: scatter each mine into its in-bounds neighbours.
    function automatic logic [255:0] model(input logic [63:0] m, input int rows,
                                           input int cols, input bit mark);
        int           cnt[64];
        int           rr, cc;
        logic [255:0] res;
        res = '0;
        foreach (cnt[i]) cnt[i] = 0;
        for (int t = 0; t < rows * cols; t++) begin
            if (m[t]) begin
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = t / cols + dr;
                        cc = t % cols + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < rows && cc >= 0 && cc < cols)
                            cnt[rr * cols + cc]++;
                    end
                end
            end
        end
        for (int t = 0; t < rows * cols; t++)
            res[4*t +: 4] = (mark && m[t]) ? 4'hF : 4'(cnt[t]);
        return res;
    endfunction

    function automatic logic [3:0] nib(input logic [255:0] v, input int t);
        return v[4*t +: 4];
    endfunction

    task automatic push_exp(input int id, input logic [255:0] adj_v, input int lat);
        exp_t e;
        e.adj = adj_v;
        e.lat = lat;
        case (id)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic mon_step(input int id, input logic busy_s, input logic ready_s,
                            input logic done_s, input logic [255:0] adj_s);
        exp_t e;
        bit   have;
        if (busy_s && !prev_busy[id]) t_start[id] = cyc;
        if (done_s && !prev_done[id]) begin
            have = 1'b0;
            case (id)
                0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
                1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
                default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
            endcase
            n_checks++;
            if (!have) begin
                n_fail++;
                $display("FAIL sb_empty%0d: got unexpected done required no completion", id);
            end else begin
                check($sformatf("sb_adj%0d", id), adj_s, e.adj);
                check($sformatf("sb_lat%0d", id), 256'(cyc - t_start[id]), 256'(e.lat));
                check($sformatf("sb_busy%0d", id), 256'(busy_s), 256'(0));
                check($sformatf("sb_ready%0d", id), 256'(ready_s), 256'(1));
            end
        end
        prev_busy[id] = busy_s;
        prev_done[id] = done_s;
    endtask

    always @(negedge clk) mon_step(0, a_busy, a_ready, a_done, a_adj);
    always @(negedge clk) mon_step(1, b_busy, b_ready, b_done, b_adj);
    always @(negedge clk) mon_step(2, c_busy, c_ready, c_done, 256'(c_adj));

    task automatic pulse(input int id, input logic [63:0] m);
        case (id)
            0: begin a_map = m; a_start = 1'b1; end
            1: begin b_map = m; b_start = 1'b1; end
            default: begin c_map = m[19:0]; c_start = 1'b1; end
        endcase
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        c_start = 1'b0;
    endtask

    task automatic wait_done(input int id, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = (id == 0) ? a_done : (id == 1) ? b_done : c_done;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_done%0d: got no done required done within %0d cycles", id, budget);
        end
    endtask

    initial begin
        logic [63:0] m;
        logic [63:0] m2;
        rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_map = '0; b_map = '0; c_map = '0;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_adj_a", a_adj, '0);
        check("rst_busy_a", 256'(a_busy), 256'(0));
        check("rst_ready_a", 256'(a_ready), 256'(1));
        check("rst_done_a", 256'(a_done), 256'(0));
        check("rst_adj_c", 256'(c_adj), '0);
        rst = 1'b1;
        @(negedge clk);

        // Empty board: all counts zero after 64 cycles.
        push_exp(0, '0, 64);
        pulse(0, '0);
        check("acc_busy_a", 256'(a_busy), 256'(1));
        check("acc_ready_a", 256'(a_ready), 256'(0));
        wait_done(0, 80);

        // Single mine in the corner, plain counts and mine tagging.
        m = 64'h1;
        push_exp(0, model(m, 8, 8, 1'b0), 64);
        pulse(0, m);
        wait_done(0, 80);
        check("a1_t0", 256'(nib(a_adj, 0)), 256'(0));
        check("a1_t1", 256'(nib(a_adj, 1)), 256'(1));
        check("a1_t8", 256'(nib(a_adj, 8)), 256'(1));
        check("a1_t9", 256'(nib(a_adj, 9)), 256'(1));
        check("a1_t2", 256'(nib(a_adj, 2)), 256'(0));
        push_exp(1, model(m, 8, 8, 1'b1), 13);
        pulse(1, m);
        wait_done(1, 30);
        check("b1_t0", 256'(nib(b_adj, 0)), 256'(15));
        check("b1_t9", 256'(nib(b_adj, 9)), 256'(1));

        // Tile 9 fully surrounded.
        m = '0;
        m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1; m[8] = 1'b1;
        m[10] = 1'b1; m[16] = 1'b1; m[17] = 1'b1; m[18] = 1'b1;
        push_exp(0, model(m, 8, 8, 1'b0), 64);
        pulse(0, m);
        wait_done(0, 80);
        check("a8_t9", 256'(nib(a_adj, 9)), 256'(8));
        check("a8_t0", 256'(nib(a_adj, 0)), 256'(2));
        check("a8_t17", 256'(nib(a_adj, 17)), 256'(4));
        push_exp(1, model(m, 8, 8, 1'b1), 13);
        pulse(1, m);
        wait_done(1, 30);
        check("b8_t9", 256'(nib(b_adj, 9)), 256'(8));
        check("b8_t0", 256'(nib(b_adj, 0)), 256'(15));

        // 4x5 board, three lanes, mine on the right edge: no wrap into the next row.
        m = 64'h10;
        push_exp(2, model(m, 4, 5, 1'b0), 7);
        pulse(2, m);
        @(negedge clk);
        check("c_unwritten_t3", 256'(c_adj[15:12]), 256'(0));
        wait_done(2, 20);
        check("c_t5", 256'(c_adj[23:20]), 256'(0));
        check("c_t3", 256'(c_adj[15:12]), 256'(1));
        check("c_t8", 256'(c_adj[35:32]), 256'(1));
        check("c_t9", 256'(c_adj[39:36]), 256'(1));

        // Start and map change during a scan are ignored.
        m = 64'h1;
        push_exp(0, model(m, 8, 8, 1'b0), 64);
        pulse(0, m);
        repeat (10) @(negedge clk);
        a_map = '1;
        a_start = 1'b1;
        repeat (3) @(negedge clk);
        a_start = 1'b0;
        wait_done(0, 80);
        check("a_snap_t9", 256'(nib(a_adj, 9)), 256'(1));

        // Restart from DONE clears results and done at the acceptance edge.
        push_exp(0, model('1, 8, 8, 1'b0), 64);
        pulse(0, '1);
        check("restart_done", 256'(a_done), 256'(0));
        check("restart_adj", a_adj, '0);
        check("restart_busy", 256'(a_busy), 256'(1));
        wait_done(0, 80);

        // Reset mid-scan discards everything; a fresh scan then completes.
        pulse(0, 64'h1);
        repeat (29) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_adj", a_adj, '0);
        check("midrst_busy", 256'(a_busy), 256'(0));
        check("midrst_ready", 256'(a_ready), 256'(1));
        check("midrst_done", 256'(a_done), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m = '0;
        m[0] = 1'b1;
        m[63] = 1'b1;
        push_exp(0, model(m, 8, 8, 1'b0), 64);
        pulse(0, m);
        wait_done(0, 80);
        check("post_t62", 256'(nib(a_adj, 62)), 256'(1));
        check("post_t54", 256'(nib(a_adj, 54)), 256'(1));
        check("post_t9", 256'(nib(a_adj, 9)), 256'(1));
        check("post_t36", 256'(nib(a_adj, 36)), 256'(0));

        // Start held high: back-to-back scans, each on the map at its acceptance edge.
        m = 64'h1;
        m2 = 64'h1 << 19;
        push_exp(2, model(m, 4, 5, 1'b0), 7);
        push_exp(2, model(m2, 4, 5, 1'b0), 7);
        c_map = m[19:0];
        c_start = 1'b1;
        @(negedge clk);
        c_map = m2[19:0];
        wait_done(2, 20);
        @(negedge clk);
        c_start = 1'b0;
        check("held_done", 256'(c_done), 256'(0));
        check("held_busy", 256'(c_busy), 256'(1));
        wait_done(2, 20);
        check("held_t18", 256'(c_adj[75:72]), 256'(1));
        check("held_t0", 256'(c_adj[3:0]), 256'(0));

        repeat (3) @(negedge clk);
        check("sb_drained", 256'(qa.size() + qb.size() + qc.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
